cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm.sv | 127 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache line refill controller.
// On a miss, issues eight pipelined word reads to memory and writes each
// returned word into the data array. The tag/valid entry is written together
// with the eighth word, and a one-cycle fill_done pulse follows.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for miss_detected; latches block base and victim way
// FILL  | issuing reads (issue_cnt < 8) and accepting returns
// DONE  | one-cycle completion pulse, then back to IDLE
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        victim_way,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        mem_req,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  data_array_offset,
    output logic        data_array_way,
    output logic [5:0]  data_array_index,
    output logic [15:0] data_out,
    output logic        write_tag_array,
    output logic        fsm_busy,
    output logic        fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] base, base_nxt;       // miss_address[15:4]: tag + index
    logic        way, way_nxt;
    logic [3:0]  issue_cnt, issue_nxt;
    logic [3:0]  rcv_cnt, rcv_nxt;

    // Byte offset within the block is irrelevant: fills are always whole blocks.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, miss_address[3:0]};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            way       <= 1'b0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            way       <= way_nxt;
            issue_cnt <= issue_nxt;
            rcv_cnt   <= rcv_nxt;
        end
    end

    // Next-state logic and the combinational request/write strobes.
    always_comb begin
        state_nxt         = state;
        base_nxt          = base;
        way_nxt           = way;
        issue_nxt         = issue_cnt;
        rcv_nxt           = rcv_cnt;
        mem_req           = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        write_tag_array   = 1'b0;
        data_array_offset = '0;

        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_nxt  = miss_address[15:4];
                    way_nxt   = victim_way;
                    issue_nxt = '0;
                    rcv_nxt   = '0;
                    state_nxt = FILL;
                end
            end

            FILL: begin
                data_array_offset = rcv_cnt[2:0];

                if (issue_cnt < 4'd8) begin
                    mem_req        = 1'b1;
                    memory_address = {base, issue_cnt[2:0], 1'b0};
                    issue_nxt      = issue_cnt + 4'd1;
                end

                // A return is only meaningful if a request is outstanding;
                // comparing against the pre-increment issue_cnt keeps a
                // same-cycle request from matching its own (impossible) data.
                if (memory_data_valid && (rcv_cnt < issue_cnt)) begin
                    write_data_array = 1'b1;
                    rcv_nxt          = rcv_cnt + 4'd1;
                    if (rcv_cnt == 4'd7) begin
                        write_tag_array = 1'b1;
                        state_nxt       = DONE;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered status and array addressing.
    assign fsm_busy         = (state == FILL);
    assign fill_done        = (state == DONE);
    assign data_array_way   = way;
    assign data_array_index = base[5:0];
    assign data_out         = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        victim_way;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  data_array_offset;
    logic        data_array_way;
    logic [5:0]  data_array_index;
    logic [15:0] data_out;
    logic        write_tag_array;
    logic        fsm_busy;
    logic        fill_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .victim_way        (victim_way),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_array_offset (data_array_offset),
        .data_array_way    (data_array_way),
        .data_array_index  (data_array_index),
        .data_out          (data_out),
        .write_tag_array   (write_tag_array),
        .fsm_busy          (fsm_busy),
        .fill_done         (fill_done)
    );

    // One refill: cycle 0 presents the miss in IDLE, cycles 1.. run the fill
    // with memory returning each request 'lat' cycles later. Expected
    // control per cycle c: mem_req in 1..8, writes in 1+lat..8+lat,
    // tag write at 8+lat, busy through 8+lat, fill_done at 9+lat.
    task automatic run_fill(input logic [15:0] a, input logic w, input int lat,
                            input logic early_spur, input logic extra,
                            input logic hold, input logic [15:0] a_alt);
        int          last;
        int          stop;
        int          nwr;
        int          ntag;
        int          ndone;
        logic        rv;
        logic [4:0]  exp_ctrl;
        logic [4:0]  got_ctrl;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        logic [2:0]  exp_off;
        last  = 9 + lat;
        stop  = extra ? last + 1 : last;
        nwr   = 0;
        ntag  = 0;
        ndone = 0;

        @(posedge clk); #1;
        miss_detected     = 1'b1;
        miss_address      = a;
        victim_way        = w;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        @(negedge clk);
        tests++;
        if ({mem_req, write_data_array, write_tag_array, fsm_busy, fill_done} !== 5'b00000) begin
            fails++;
            $display("FAIL idle_before_fill addr=%h ctrl got %b exp 00000", a,
                     {mem_req, write_data_array, write_tag_array, fsm_busy, fill_done});
        end

        for (int c = 1; c <= stop; c++) begin
            @(posedge clk); #1;
            if (!hold) miss_detected = 1'b0;
            miss_address      = a_alt;
            victim_way        = ~w;
            rv                = (c >= 1 + lat) && (c <= 8 + lat);
            memory_data_valid = rv || (early_spur && c == 1) || (extra && c > 8 + lat);
            exp_data          = a + 16'(c * 16'h1111);
            memory_data       = exp_data;
            @(negedge clk);

            exp_ctrl = {(c <= 8), rv, (c == 8 + lat), (c <= 8 + lat), (c == 9 + lat)};
            got_ctrl = {mem_req, write_data_array, write_tag_array, fsm_busy, fill_done};
            nwr   += int'(write_data_array);
            ntag  += int'(write_tag_array);
            ndone += int'(fill_done);
            tests++;
            if (got_ctrl !== exp_ctrl) begin
                fails++;
                $display("FAIL ctrl addr=%h lat=%0d c=%0d {req,wr,tag,busy,done} got %b exp %b",
                         a, lat, c, got_ctrl, exp_ctrl);
            end

            if (c <= 8) begin
                exp_addr = {a[15:4], 4'h0} + 16'((c - 1) * 2);
                tests++;
                if (memory_address !== exp_addr) begin
                    fails++;
                    $display("FAIL mem_addr c=%0d got %h exp %h", c, memory_address, exp_addr);
                end
            end

            if (c <= 8 + lat) begin
                tests++;
                if ({data_array_way, data_array_index} !== {w, a[9:4]}) begin
                    fails++;
                    $display("FAIL way_index c=%0d got %b/%h exp %b/%h", c,
                             data_array_way, data_array_index, w, a[9:4]);
                end
            end

            if (rv) begin
                exp_off = 3'(c - 1 - lat);
                tests++;
                if ({data_array_offset, data_out} !== {exp_off, exp_data}) begin
                    fails++;
                    $display("FAIL write_word c=%0d offset/data got %0d/%h exp %0d/%h", c,
                             data_array_offset, data_out, exp_off, exp_data);
                end
            end
        end

        tests++;
        if (nwr != 8 || ntag != 1 || ndone != 1) begin
            fails++;
            $display("FAIL fill_counts addr=%h writes/tags/dones got %0d/%0d/%0d exp 8/1/1",
                     a, nwr, ntag, ndone);
        end
        if (!hold) miss_detected = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'hBEEF;
        victim_way        = 1'b1;
        memory_data_valid = 1'b1;
        memory_data       = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        memory_data_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({mem_req, memory_address, write_data_array, data_array_offset, data_array_way,
             data_array_index, data_out, write_tag_array, fsm_busy, fill_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs req=%b addr=%h wr=%b off=%0d way=%b idx=%h dout=%h tag=%b busy=%b done=%b exp all 0",
                     mem_req, memory_address, write_data_array, data_array_offset,
                     data_array_way, data_array_index, data_out, write_tag_array,
                     fsm_busy, fill_done);
        end
        miss_detected = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_spurious;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            memory_data_valid = 1'b1;
            memory_data       = 16'h5A5A;
            @(negedge clk);
            tests++;
            if ({mem_req, write_data_array, write_tag_array, fsm_busy, fill_done,
                 data_array_offset} !== 8'h00) begin
                fails++;
                $display("FAIL idle_spurious c=%0d ctrl+off got %b exp 00000000", c,
                         {mem_req, write_data_array, write_tag_array, fsm_busy, fill_done,
                          data_array_offset});
            end
        end
        memory_data_valid = 1'b0;
    endtask

    task automatic test_fill_latency4;
        run_fill(16'h1A36, 1'b1, 4, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    endtask

    task automatic test_fill_latency1;
        run_fill(16'h0F58, 1'b0, 1, 1'b0, 1'b0, 1'b0, 16'h1234);
    endtask

    task automatic test_spurious_valid;
        run_fill(16'hFFF2, 1'b1, 3, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_mid_fill;
        logic [4:0] exp_ctrl;
        logic [4:0] got_ctrl;
        @(posedge clk); #1;
        miss_detected = 1'b1;
        miss_address  = 16'h2468;
        victim_way    = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            miss_detected     = 1'b0;
            rst_n             = (c == 6) ? 1'b0 : 1'b1;
            memory_data_valid = (c >= 5) && (c <= 12);
            memory_data       = (c == 7) ? 16'h0000 : 16'(c * 16'h0F0F);
            @(negedge clk);
            if (c <= 6) exp_ctrl = {1'b1, (c >= 5), 1'b0, 1'b1, 1'b0};
            else        exp_ctrl = 5'b00000;
            got_ctrl = {mem_req, write_data_array, write_tag_array, fsm_busy, fill_done};
            tests++;
            if (got_ctrl !== exp_ctrl) begin
                fails++;
                $display("FAIL reset_mid_fill c=%0d {req,wr,tag,busy,done} got %b exp %b",
                         c, got_ctrl, exp_ctrl);
            end
            if (c == 7) begin
                tests++;
                if ({memory_address, data_array_offset, data_array_way, data_array_index,
                     data_out} !== '0) begin
                    fails++;
                    $display("FAIL reset_mid_fill_outputs addr=%h off=%0d way=%b idx=%h dout=%h exp 0",
                             memory_address, data_array_offset, data_array_way,
                             data_array_index, data_out);
                end
            end
        end
        memory_data_valid = 1'b0;
        run_fill(16'h3C5A, 1'b0, 2, 1'b0, 1'b0, 1'b0, 16'hAAAA);
    endtask

    task automatic test_back_to_back;
        // Miss held high with a new address presented during the first fill:
        // the second fill must start from IDLE and latch that new address.
        run_fill(16'h4C20, 1'b0, 4, 1'b0, 1'b0, 1'b1, 16'h8ABE);
        run_fill(16'h8ABE, 1'b1, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_idle_spurious();
        test_fill_latency4();
        test_fill_latency1();
        test_spurious_valid();
        test_reset_mid_fill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "time limit");
    end

endmodule
